// File: rtl/xpb_lut_bank.sv
// Multi-channel lookup table of precomputed xpb values. A load sequence
// fills the table, after which NUM_CH indices per cycle are read through a
// two-stage pipeline (index register, then data register).
module xpb_lut_bank #(
  parameter int DATA_W = 1024,
  parameter int IDX_W  = 5,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  input  logic                     lk_valid,
  input  logic [NUM_CH*IDX_W-1:0]  lk_idx,
  output logic                     tbl_ready,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     lk_drop
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t                    state, state_nxt;
  logic [DATA_W-1:0]         tbl [DEPTH];
  logic                      accept;
  logic                      vld_p0;
  logic [NUM_CH*IDX_W-1:0]   idx_p0;
  logic [NUM_CH*DATA_W-1:0]  rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wr_en) state_nxt = wr_last ? READY : LOADING;
  end

  assign tbl_ready = (state == READY);
  assign accept    = lk_valid && tbl_ready && !wr_en;

  // Storage survives reset; entry 0 is never stored and reads as zero.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr != '0)) tbl[wr_addr] <= wr_data;
  end

  // Stage 0: capture indices of an accepted request, flag rejected ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      lk_drop <= 1'b0;
    end else begin
      vld_p0  <= accept;
      lk_drop <= lk_valid && !accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) idx_p0 <= lk_idx;
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx_p0[c*IDX_W +: IDX_W] != '0)
        rd_data[c*DATA_W +: DATA_W] = tbl[idx_p0[c*IDX_W +: IDX_W]];
    end
  end

  // Stage 1: register read data; output holds between valid results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Randomized and directed bench for xpb_lut_bank against a queue-based
// reference model of the table, load state and response timing.
module tb_xpb_lut_bank;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 5;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int LW     = NUM_CH * IDX_W;
  localparam int OW     = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              lk_valid;
  logic [LW-1:0]     lk_idx;
  logic              tbl_ready;
  logic              out_valid;
  logic [OW-1:0]     data_out;
  logic              lk_drop;

  xpb_lut_bank #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last), .lk_valid(lk_valid),
    .lk_idx(lk_idx), .tbl_ready(tbl_ready), .out_valid(out_valid),
    .data_out(data_out), .lk_drop(lk_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [OW-1:0] d;
  } resp_t;

  logic [DATA_W-1:0] mdl [DEPTH];
  resp_t             exp_q[$];
  logic [OW-1:0]     last_d;
  bit                m_ready;
  bit                m_drop;
  int                cyc;
  int                n_chk;
  int                n_fail;

  task automatic chk(input string tag, input logic [OW-1:0] got,
                     input logic [OW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] lookup(input logic [LW-1:0] li);
    logic [OW-1:0] d;
    d = '0;
    for (int c = 0; c < NUM_CH; c++)
      d[c*DATA_W +: DATA_W] = mdl[li[c*IDX_W +: IDX_W]];
    return d;
  endfunction

  function automatic logic [LW-1:0] splat(input int k);
    logic [LW-1:0] li;
    for (int c = 0; c < NUM_CH; c++) li[c*IDX_W +: IDX_W] = IDX_W'(k);
    return li;
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit r, input bit we, input int wa,
                      input logic [DATA_W-1:0] wd, input bit wl,
                      input bit lv, input logic [LW-1:0] li);
    resp_t r_item;
    bit    acc;
    bit    exp_ov;
    rst_n = r; wr_en = we; wr_addr = IDX_W'(wa); wr_data = wd;
    wr_last = wl; lk_valid = lv; lk_idx = li;
    acc = r && lv && m_ready && !we;
    if (!r) begin
      exp_q.delete();
      last_d  = '0;
      m_drop  = 1'b0;
      m_ready = 1'b0;
    end else begin
      if (acc) begin
        r_item.due = cyc + 2;
        r_item.d   = lookup(li);
        exp_q.push_back(r_item);
      end
      m_drop = lv && !acc;
      if (we) m_ready = wl;
    end
    if (we && wa != 0) mdl[wa] = wd;
    @(posedge clk);
    #1;
    cyc++;
    exp_ov = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_ov = 1'b1;
      last_d = exp_q[0].d;
      void'(exp_q.pop_front());
    end
    chk("tbl_ready", OW'(tbl_ready), OW'(m_ready));
    chk("lk_drop",   OW'(lk_drop),   OW'(m_drop));
    chk("out_valid", OW'(out_valid), OW'(exp_ov));
    chk("data_out",  data_out,       last_d);
  endtask

  task automatic idle();
    step(1, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic load_all();
    for (int k = 1; k < DEPTH; k++)
      step(1, 1, k, DATA_W'(32'h1000 + k), (k == DEPTH-1), 0, '0);
  endtask

  initial begin
    logic [LW-1:0] li;
    n_chk = 0; n_fail = 0; cyc = 0; m_ready = 0; m_drop = 0; last_d = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    step(0, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, '0, 0, 1, '1);

    // Lookup while EMPTY is rejected
    step(1, 0, 0, '0, 0, 1, splat(3));
    idle(); idle();
    chk("empty_data", data_out, '0);

    // Full load then a mixed-index lookup
    load_all();
    chk("ready_after_load", OW'(tbl_ready), OW'(1));
    li = {IDX_W'(31), IDX_W'(17), IDX_W'(1), IDX_W'(0)};
    step(1, 0, 0, '0, 0, 1, li);
    idle(); idle();
    chk("mixed_lookup", data_out,
        {64'h101F, 64'h1011, 64'h1001, 64'h0});

    // Eight back-to-back lookups
    for (int k = 1; k <= 8; k++) step(1, 0, 0, '0, 0, 1, splat(k));
    idle(); idle(); idle();
    chk("burst_last", data_out, {4{64'h1008}});

    // Rewrite during an in-flight lookup
    step(1, 0, 0, '0, 0, 1, splat(5));
    step(1, 1, 5, 64'hABC, 0, 1, splat(5));
    step(1, 0, 0, '0, 0, 1, splat(5));
    chk("old_value", data_out, {4{64'h1005}});
    step(1, 1, 1, 64'h1001, 1, 0, '0);
    step(1, 0, 0, '0, 0, 1, splat(5));
    idle(); idle();
    chk("new_value", data_out, {4{64'hABC}});

    // Writes to entry 0 never change its read value
    step(1, 1, 0, 64'hFFFF, 1, 0, '0);
    step(1, 0, 0, '0, 0, 1, splat(0));
    idle(); idle();
    chk("entry0_zero", data_out, '0);

    // Randomized traffic including reloads and occasional resets
    for (int n = 0; n < 400; n++) begin
      bit rr, we, wl, lv;
      int wa;
      rr = ($urandom_range(0, 49) != 0);
      we = ($urandom_range(0, 9) == 0);
      wl = ($urandom_range(0, 2) == 0);
      lv = ($urandom_range(0, 3) != 0);
      wa = $urandom_range(0, DEPTH-1);
      step(rr, we, wa, {$urandom, $urandom}, wl, lv, LW'($urandom));
    end

    // Reset with two lookups in flight
    step(1, 1, 2, 64'h2222, 1, 0, '0);
    step(1, 0, 0, '0, 0, 1, splat(2));
    step(1, 0, 0, '0, 0, 1, splat(7));
    step(0, 0, 0, '0, 0, 0, '0);
    chk("rst_ready", OW'(tbl_ready), OW'(0));
    step(1, 0, 0, '0, 0, 1, splat(2));
    chk("post_rst_no_valid", OW'(out_valid), OW'(0));
    idle();
    chk("post_rst_drop_done", OW'(lk_drop), OW'(0));
    idle();

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xpb_lut_bank.md
XPB_LUT_BANK -- requirements
Module: xpb_lut_bank

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 1024, the width of one precomputed xpb value.
REQ-002 The block SHALL expose parameter IDX_W, default 5, the index width; table depth is 2^IDX_W.
REQ-003 The block SHALL expose parameter NUM_CH, default 4, the number of independent parallel lookup channels.
REQ-004 The block SHALL have a port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have a port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have a port wr_en, input, 1 bit: table write strobe.
REQ-007 The block SHALL have a port wr_addr, input, IDX_W bits: table write index.
REQ-008 The block SHALL have a port wr_data, input, DATA_W bits: table write value.
REQ-009 The block SHALL have a port wr_last, input, 1 bit: qualifies the final write of a load.
REQ-010 The block SHALL have a port lk_valid, input, 1 bit: lookup request for all channels.
REQ-011 The block SHALL have a port lk_idx, input, NUM_CH*IDX_W bits: the per-channel index, with channel c at bits [c*IDX_W +: IDX_W].
REQ-012 The block SHALL have a port tbl_ready, output, 1 bit: the table is loaded and lookups are accepted.
REQ-013 The block SHALL have a port out_valid, output, 1 bit: data_out is valid this cycle.
REQ-014 The block SHALL have a port data_out, output, NUM_CH*DATA_W bits: the per-channel value, with channel c at bits [c*DATA_W +: DATA_W].
REQ-015 The block SHALL have a port lk_drop, output, 1 bit: a single-cycle pulse flagging a rejected lookup.

Function
REQ-016 The block SHALL implement state machine states EMPTY, LOADING and READY; tbl_ready SHALL be 1 only in READY.
REQ-017 wr_en=1 in any state SHALL write wr_data to entry wr_addr and move the state to LOADING, unless wr_last=1.
REQ-018 wr_en=1 with wr_last=1 SHALL perform the write and move the state to READY on the next cycle.
REQ-019 A write in READY SHALL start a reload, with tbl_ready=0 from the next cycle.
REQ-020 Entry 0 SHALL always read as zero; writes with wr_addr=0 SHALL be ignored for data but still drive state transitions.
REQ-021 A lookup SHALL be accepted when lk_valid=1, the state is READY and wr_en=0.
REQ-022 An accepted lookup SHALL return all NUM_CH results with out_valid=1 exactly 2 cycles later: stage 1 registers the indices, stage 2 registers the data.
REQ-023 Back-to-back lookups SHALL be accepted every cycle, with full throughput and no bubbles.
REQ-024 lk_valid=1 when not accepted SHALL assert lk_drop for exactly one cycle, 1 cycle later; out_valid SHALL not assert for that request.
REQ-025 When out_valid=0, data_out SHALL hold its last valid value.
REQ-026 A lookup accepted in the cycle before a write begins SHALL return the pre-write contents; the pipeline SHALL not be flushed by writes.
REQ-027 Channels SHALL be fully independent; identical indices on several channels SHALL return identical values.
REQ-028 The index SHALL be interpreted as unsigned, with no modular wrap beyond 2^IDX_W-1.
REQ-029 Table storage SHALL be registers or distributed RAM, with no handshake on the write port; one write per cycle SHALL always be accepted.

Reset
REQ-030 While rst_n=0 at a clock edge, the state SHALL go to EMPTY, with tbl_ready=0, out_valid=0, lk_drop=0, data_out=0 and the pipeline valid bits cleared.
REQ-031 Reset SHALL not clear the table contents; after reset, a full reload SHALL be required before lookups are accepted.
REQ-032 Lookups in flight when reset is asserted SHALL be discarded and SHALL produce no out_valid.

Verification
REQ-033 Load entries 1..31 with value 0x1000+k, the last with wr_last=1; then look up idx {0,1,17,31} -> tbl_ready=1 after the last write; 2 cycles later out_valid=1 and data_out={0,0x1001,0x1011,0x101F}.
REQ-034 In EMPTY, drive lk_valid=1 -> lk_drop=1 one cycle later, out_valid stays 0, data_out stays 0.
REQ-035 Drive 8 consecutive lookups with indices 1..8 on all channels -> 8 consecutive out_valid cycles in order, starting 2 cycles after the first.
REQ-036 In READY, rewrite entry 5 to 0xABC (without wr_last) while a lookup of idx 5 was accepted one cycle earlier -> the lookup returns the old value; the next lookup is dropped; after wr_last, idx 5 returns 0xABC.
REQ-037 Write 0xFFFF to entry 0 -> a subsequent lookup of idx 0 returns 0.
REQ-038 Assert rst_n=0 for one cycle with 2 lookups in flight -> no out_valid, tbl_ready=0; a lookup after reset is dropped.
